restoring_div_nbit: RTL and testbench

RESTORING_DIV_NBIT -- requirements
Module: restoring_div_nbit

---
 rtl/div_pkg.sv | 14 +
 rtl/full_adder.sv | 17 +
 rtl/sub_borrow_nbit.sv | 33 +++
 rtl/restoring_div_nbit.sv | 156 +++++++++++++++
 tb/tb_restoring_div_nbit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider.
//   DIV_N_DEFAULT : default operand/result width.
//   STATE_W       : width of the divider FSM state encoding.
//   S_IDLE/S_RUN/S_DONE : FSM state encodings.
package div_pkg;

  localparam int DIV_N_DEFAULT = 8;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the ripple subtractor.
//   a_i, b_i : operand bits
//   ci_i     : carry in
//   s_o      : sum bit
//   co_o     : carry out
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/sub_borrow_nbit.sv
// W-bit ripple subtractor: diff = a - b, borrow set when b > a.
// Built as a + ~b + 1, so a final carry-out of 1 means "no borrow".
//   a, b   : unsigned operands, W bits
//   diff   : a - b modulo 2**W
//   borrow : 1 when a < b
module sub_borrow_nbit #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0]   carry;
  logic [W-1:0] b_n;

  assign b_n      = ~b;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a_i  (a[i]),
      .b_i  (b_n[i]),
      .ci_i (carry[i]),
      .s_o  (diff[i]),
      .co_o (carry[i+1])
    );
  end

  assign borrow = ~carry[W];

endmodule

// File: rtl/restoring_div_nbit.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
//   clk, rst      : clock, synchronous active-high reset
//   start         : request a division (accepted in IDLE or DONE only)
//   dividend      : N-bit unsigned dividend, captured on accepted start
//   divisor       : N-bit unsigned divisor, captured on accepted start
//   busy          : high while iterating; start is ignored then
//   done          : one-cycle pulse, results valid
//   quotient      : N-bit quotient (all ones on divide by zero)
//   remainder     : N-bit remainder (dividend on divide by zero)
//   div_by_zero   : set with done when the captured divisor was zero
//   dbg_state_o   : current FSM state, for observation only
//
// Handshake: start is a request sampled on every rising edge; it is taken
// only when busy is low. Results are stable from the done cycle until the
// next accepted start, and are not meaningful again until the next done.
module restoring_div_nbit
  import div_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N-1:0]       dividend,
  input  logic [N-1:0]       divisor,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       quotient,
  output logic [N-1:0]       remainder,
  output logic               div_by_zero,
  output logic [STATE_W-1:0] dbg_state_o
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N-1:0]       dsr_q, dsr_d;
  logic [N-1:0]       quo_q, quo_d;
  logic [N-1:0]       rem_q, rem_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic               dsr_zero;
  logic [N:0]         trial_a;
  logic [N:0]         trial_b;
  logic [N:0]         trial_diff;
  logic               trial_borrow;
  logic               unused_diff_msb;

  assign accept   = start && (state_q != S_RUN);
  assign dsr_zero = (divisor == '0);

  // quo_q starts as the dividend and shifts left each iteration: its MSB
  // feeds the partial remainder, its LSB receives the new quotient bit.
  assign trial_a = {rem_q, quo_q[N-1]};
  assign trial_b = {1'b0, dsr_q};

  // N+1 bits so a divisor with its MSB set can never overflow the trial.
  sub_borrow_nbit #(.W(N + 1)) u_sub (
    .a      (trial_a),
    .b      (trial_b),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // When there is no borrow the difference is below the divisor, so its
  // top bit is always zero and only N bits are kept.
  assign unused_diff_msb = trial_diff[N];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = dsr_zero ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = (state_q == S_RUN);
    done        = (state_q == S_DONE);
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
    dbg_state_o = state_q;
  end

  // Datapath next values
  always_comb begin
    cnt_d = cnt_q;
    dsr_d = dsr_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    if (accept) begin
      dsr_d = divisor;
      if (dsr_zero) begin
        quo_d = '1;
        rem_d = dividend;
        dbz_d = 1'b1;
        cnt_d = '0;
      end else begin
        quo_d = dividend;
        rem_d = '0;
        dbz_d = 1'b0;
        cnt_d = CNT_LAST;
      end
    end else if (state_q == S_RUN) begin
      quo_d = {quo_q[N-2:0], ~trial_borrow};
      // Restore on borrow: keep the shifted partial remainder unchanged.
      rem_d = trial_borrow ? trial_a[N-1:0] : trial_diff[N-1:0];
      cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      dsr_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dsr_q <= dsr_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end

endmodule

// File: tb/tb_restoring_div_nbit.sv
// Bench for restoring_div_nbit: one N=8 lane and one N=16 lane share a clock.
// Cycle numbering: start is driven in cycle 0 and sampled at the edge that
// ends it; cycle k is the period after the k-th following edge. A normal
// division shows busy in cycles 1..N and done in cycle N+1; a zero divisor
// goes straight to done in cycle 1.
module tb_restoring_div_nbit;

  localparam int NL = 2;

  logic        clk;
  logic        rst;
  logic        start_s [NL];
  logic [31:0] dvd_s   [NL];
  logic [31:0] dsr_s   [NL];
  logic        busy_s  [NL];
  logic        done_s  [NL];
  logic        dbz_s   [NL];
  logic [31:0] quo_s   [NL];
  logic [31:0] rem_s   [NL];
  logic        chk_en;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- DUT lanes + behavioural model ----------------
  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int W = (g == 0) ? 8 : 16;
    localparam logic [31:0] MASK = (32'd1 << W) - 32'd1;

    logic [W-1:0] q_w, r_w;
    logic [1:0]   st_w;

    restoring_div_nbit #(.N(W)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start_s[g]),
      .dividend    (dvd_s[g][W-1:0]),
      .divisor     (dsr_s[g][W-1:0]),
      .busy        (busy_s[g]),
      .done        (done_s[g]),
      .quotient    (q_w),
      .remainder   (r_w),
      .div_by_zero (dbz_s[g]),
      .dbg_state_o (st_w)
    );

    assign quo_s[g] = 32'(q_w);
    assign rem_s[g] = 32'(r_w);

    // Scoreboard entry: {quotient, remainder, dividend, divisor}
    logic [127:0] exp_q[$];
    logic         m_busy  = 1'b0;
    logic         m_done  = 1'b0;
    logic         m_valid = 1'b1;
    logic         m_z     = 1'b0;
    int           m_left  = 0;
    logic [31:0]  m_q = '0, m_r = '0, m_a = '0, m_b = '0;

    always @(posedge clk) begin
      if (rst) begin
        m_busy  <= 1'b0;
        m_done  <= 1'b0;
        m_valid <= 1'b1;
        m_z     <= 1'b0;
        m_q     <= '0;
        m_r     <= '0;
        m_left  <= 0;
        exp_q.delete();
      end else if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1 && exp_q.size() > 0) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          m_valid <= 1'b1;
          m_z     <= 1'b0;
          {m_q, m_r, m_a, m_b} <= exp_q.pop_front();
        end
      end else begin
        m_done <= 1'b0;
        if (start_s[g]) begin
          if (dsr_s[g] == 32'd0) begin
            m_done  <= 1'b1;
            m_valid <= 1'b1;
            m_z     <= 1'b1;
            m_q     <= MASK;
            m_r     <= dvd_s[g];
            m_a     <= dvd_s[g];
            m_b     <= '0;
          end else begin
            m_busy  <= 1'b1;
            m_left  <= W;
            m_valid <= 1'b0;
            exp_q.push_back({dvd_s[g] / dsr_s[g], dvd_s[g] % dsr_s[g], dvd_s[g], dsr_s[g]});
          end
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("lane%0d busy", g), 64'(busy_s[g]), 64'(m_busy));
        check($sformatf("lane%0d done", g), 64'(done_s[g]), 64'(m_done));
        if (m_valid) begin
          check($sformatf("lane%0d quotient", g), 64'(quo_s[g]), 64'(m_q));
          check($sformatf("lane%0d remainder", g), 64'(rem_s[g]), 64'(m_r));
          check($sformatf("lane%0d div_by_zero", g), 64'(dbz_s[g]), 64'(m_z));
        end
        if (m_done && !m_z) begin
          check($sformatf("lane%0d q*d+r==a", g),
                64'(quo_s[g]) * 64'(m_b) + 64'(rem_s[g]), 64'(m_a));
          check($sformatf("lane%0d r<d", g), 64'(rem_s[g] < m_b), 64'd1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int g, input logic [31:0] a, input logic [31:0] b);
    start_s[g] = 1'b1;
    dvd_s[g]   = a;
    dsr_s[g]   = b;
  endtask

  // Waits for done with a cycle budget; checks the latency seen.
  task automatic wait_done(input int g, input string name, input int exp_cyc);
    int cyc;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      start_s[g] = 1'b0;
      if (done_s[g]) break;
    end
    check({name, " latency"}, 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic check_res(input int g, input string name, input logic [31:0] eq,
                           input logic [31:0] er, input logic ez);
    check({name, " q"}, 64'(quo_s[g]), 64'(eq));
    check({name, " r"}, 64'(rem_s[g]), 64'(er));
    check({name, " dbz"}, 64'(dbz_s[g]), 64'(ez));
  endtask

  task automatic op0(input string name, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [31:0] eq, input logic [31:0] er,
                     input logic ez);
    drive(0, a, b);
    wait_done(0, name, lat);
    check_res(0, name, eq, er, ez);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_dsr(input logic [31:0] mask);
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return mask;
      3:       return $urandom_range(2, 15);
      default: return $urandom() & mask;
    endcase
  endfunction

  task automatic rand_ops(input int g, input int w, input int count);
    logic [31:0] mask;
    int          cyc;
    mask = (32'd1 << w) - 32'd1;
    for (int i = 0; i < count; i++) begin
      drive(g, $urandom() & mask, rnd_dsr(mask));
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        // Occasional start while busy must be ignored.
        start_s[g] = ($urandom_range(0, 7) == 0);
        dvd_s[g]   = $urandom() & mask;
        dsr_s[g]   = rnd_dsr(mask);
      end while (!done_s[g] && cyc < w + 4);
      check($sformatf("lane%0d done reached", g), 64'(done_s[g]), 64'd1);
      if (!done_s[g]) break;
      if ($urandom_range(0, 1) == 1) begin
        start_s[g] = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end
    start_s[g] = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst    = 1'b1;
    chk_en = 1'b0;
    for (int i = 0; i < NL; i++) begin
      start_s[i] = 1'b0;
      dvd_s[i]   = '0;
      dsr_s[i]   = '0;
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < NL; i++) begin
      check($sformatf("reset lane%0d busy", i), 64'(busy_s[i]), 64'd0);
      check($sformatf("reset lane%0d done", i), 64'(done_s[i]), 64'd0);
      check_res(i, $sformatf("reset lane%0d", i), 32'd0, 32'd0, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Hand-computed directed cases, N=8
    op0("200/7",   200, 7,   9, 28,  4,   1'b0);
    op0("255/1",   255, 1,   9, 255, 0,   1'b0);
    op0("5/9",     5,   9,   9, 0,   5,   1'b0);
    op0("255/255", 255, 255, 9, 1,   0,   1'b0);
    op0("128/128", 128, 128, 9, 1,   0,   1'b0);
    op0("100/0",   100, 0,   1, 255, 100, 1'b1);

    // Start during RUN ignored, then back-to-back start in the done cycle
    drive(0, 200, 7);
    repeat (4) begin
      @(negedge clk);
      start_s[0] = 1'b0;
    end
    drive(0, 50, 5);
    wait_done(0, "ignored start 200/7", 5);
    check_res(0, "ignored start 200/7", 28, 4, 1'b0);
    drive(0, 50, 5);
    wait_done(0, "b2b 50/5", 9);
    check_res(0, "b2b 50/5", 10, 0, 1'b0);
    @(negedge clk);

    // Reset in cycle 5 of a run aborts it
    drive(0, 200, 7);
    repeat (5) begin
      @(negedge clk);
      start_s[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(busy_s[0]), 64'd0);
    check("abort done", 64'(done_s[0]), 64'd0);
    check_res(0, "abort", 0, 0, 1'b0);
    op0("60/7 after rst", 60, 7, 9, 8, 4, 1'b0);

    // Randomised sweep on both lanes
    fork
      rand_ops(0, 8, 2500);
      rand_ops(1, 16, 1500);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
